// File: rtl/apu_dispatcher_pkg.sv
// Shared types for the APU dispatcher: request payload and dispatcher FSM encoding.
package apu_dispatcher_pkg;

  // One queued APU instruction plus the writeback info it carries along.
  typedef struct packed {
    logic [5:0]       op;
    logic [2:0][31:0] operands;
    logic [14:0]      flags;
    logic [4:0]       rd;
    logic             wb;
  } apu_req_t;

  typedef logic [1:0] apu_disp_state_t;

  localparam apu_disp_state_t DISP_IDLE      = 2'd0;
  localparam apu_disp_state_t DISP_REQ       = 2'd1;
  localparam apu_disp_state_t DISP_WAIT_RESP = 2'd2;

endpackage

// File: rtl/apu_req_fifo.sv
// Request queue between the core issue stage and the dispatcher FSM.
// Pushes are refused when full (no bypass); flush empties the queue and wins over a push.
module apu_req_fifo
  import apu_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     n_reset,
  input  logic     push,
  input  apu_req_t push_data,
  input  logic     pop,
  input  logic     flush,
  output apu_req_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  apu_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_en;
  logic            pop_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_en  = push && !full && !flush;
  assign pop_en   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      if (push_en && !pop_en)      count <= count + CW'(1);
      else if (!push_en && pop_en) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/apu_dispatcher.sv
// Core-side initiator of the APU offload protocol: queues issued instructions, runs one
// request/grant/response transaction at a time, and returns results to the register file.
module apu_dispatcher
  import apu_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [5:0]       issue_op,
  input  logic [2:0][31:0] issue_operands,
  input  logic [14:0]      issue_flags,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wb,
  input  logic             flush,
  output logic             apu_req,
  output logic [5:0]       apu_op,
  output logic [2:0][31:0] apu_operands,
  output logic [14:0]      apu_flags_o,
  input  logic             apu_gnt,
  input  logic             apu_rvalid,
  input  logic [31:0]      apu_result,
  input  logic [4:0]       apu_flags_i,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_flags,
  output logic             wb_err,
  output logic             busy,
  output logic             proto_err
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  apu_disp_state_t  state_q, state_d;
  apu_req_t         req_q;
  apu_req_t         issue_entry;
  apu_req_t         head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty;
  logic             pop;
  logic             complete;
  logic             timed_out;

  logic             wb_valid_q;
  logic [4:0]       wb_rd_q;
  logic [31:0]      wb_data_q;
  logic [4:0]       wb_flags_q;
  logic             wb_err_q;
  logic             proto_err_q;

  assign issue_entry = '{op:       issue_op,
                         operands: issue_operands,
                         flags:    issue_flags,
                         rd:       issue_rd,
                         wb:       issue_wb};

  apu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (issue_valid),
    .push_data (issue_entry),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM next state, queue pop and completion detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      DISP_IDLE: begin
        // A flush in the same cycle drops the head instead of dispatching it.
        if (!fifo_empty && !flush) begin
          pop     = 1'b1;
          state_d = DISP_REQ;
        end
      end
      DISP_REQ: begin
        if (apu_gnt) begin
          state_d = DISP_WAIT_RESP;
          cnt_d   = '0;
        end
      end
      DISP_WAIT_RESP: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (apu_rvalid) begin
          complete = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_TO)) begin
          complete  = 1'b1;
          timed_out = 1'b1;
        end
        if (complete) begin
          if (!fifo_empty && !flush) begin
            pop     = 1'b1;
            state_d = DISP_REQ;
          end else begin
            state_d = DISP_IDLE;
          end
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  // FSM state, request register and timeout counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= DISP_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) req_q <= head;
    end
  end

  // Writeback register: one-cycle strobe, payload held until the next completion.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      wb_valid_q <= complete && (timed_out || req_q.wb);
      wb_err_q   <= complete && timed_out;
      if (complete) begin
        wb_rd_q    <= req_q.rd;
        wb_data_q  <= timed_out ? 32'd0 : apu_result;
        wb_flags_q <= timed_out ? 5'd0 : apu_flags_i;
      end
    end
  end

  // Sticky protocol violation flag: response outside WAIT_RESP or grant without request.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      proto_err_q <= 1'b0;
    end else if ((apu_rvalid && (state_q != DISP_WAIT_RESP)) ||
                 (apu_gnt && (state_q != DISP_REQ))) begin
      proto_err_q <= 1'b1;
    end
  end

  assign issue_ready  = !fifo_full;
  assign apu_req      = (state_q == DISP_REQ);
  assign apu_op       = req_q.op;
  assign apu_operands = req_q.operands;
  assign apu_flags_o  = req_q.flags;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_flags     = wb_flags_q;
  assign wb_err       = wb_err_q;
  assign busy         = !fifo_empty || (state_q != DISP_IDLE);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_apu_dispatcher.sv
// Self-checking bench for apu_dispatcher: directed scenarios plus a randomized run
// checked against an in-order transaction model.
module tb_apu_dispatcher;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs1, rs2, rs3;
    logic [14:0] flags;
    logic [4:0]  rd;
    logic        wb;
  } ent_t;

  typedef struct {
    bit          to;
    logic [5:0]  op;
    logic [31:0] rs1, rs2, rs3;
    logic [14:0] flg;
    logic        wbv, wberr, req_after;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [4:0]  wbf;
  } obs_t;

  logic             clk;
  logic             n_reset;
  logic             issue_valid;
  logic             issue_ready;
  logic [5:0]       issue_op;
  logic [2:0][31:0] issue_operands;
  logic [14:0]      issue_flags;
  logic [4:0]       issue_rd;
  logic             issue_wb;
  logic             flush;
  logic             apu_req;
  logic [5:0]       apu_op;
  logic [2:0][31:0] apu_operands;
  logic [14:0]      apu_flags_o;
  logic             apu_gnt;
  logic             apu_rvalid;
  logic [31:0]      apu_result;
  logic [4:0]       apu_flags_i;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [4:0]       wb_flags;
  logic             wb_err;
  logic             busy;
  logic             proto_err;

  int checks;
  int failures;
  ent_t exp_q[$];

  apu_dispatcher #(
    .DEPTH   (2),
    .TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_op       (issue_op),
    .issue_operands (issue_operands),
    .issue_flags    (issue_flags),
    .issue_rd       (issue_rd),
    .issue_wb       (issue_wb),
    .flush          (flush),
    .apu_req        (apu_req),
    .apu_op         (apu_op),
    .apu_operands   (apu_operands),
    .apu_flags_o    (apu_flags_o),
    .apu_gnt        (apu_gnt),
    .apu_rvalid     (apu_rvalid),
    .apu_result     (apu_result),
    .apu_flags_i    (apu_flags_i),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_flags       (wb_flags),
    .wb_err         (wb_err),
    .busy           (busy),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [5:0] op, input logic [31:0] rs1,
                              input logic [4:0] rd, input logic wb);
    ent_t e;
    e.op    = op;
    e.rs1   = rs1;
    e.rs2   = $urandom;
    e.rs3   = $urandom;
    e.flags = 15'($urandom);
    e.rd    = rd;
    e.wb    = wb;
    return e;
  endfunction

  task automatic set_issue(input ent_t e);
    issue_op       = e.op;
    issue_operands = {e.rs3, e.rs2, e.rs1};
    issue_flags    = e.flags;
    issue_rd       = e.rd;
    issue_wb       = e.wb;
  endtask

  // Offer one entry and hold it until accepted (bounded).
  task automatic issue(input ent_t e, output bit ok);
    logic r;
    set_issue(e);
    issue_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      r = issue_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    issue_valid = 1'b0;
  endtask

  // Accelerator responder: wait for a request, grant after gd cycles, respond rl cycles
  // after the grant edge, then sample the writeback interface.
  task automatic serve(input int gd, input int rl, input logic [31:0] res,
                       input logic [4:0] f, output obs_t o);
    o = '{default: '0};
    o.to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (apu_req === 1'b1) begin
        o.to = 1'b0;
        break;
      end
      tick();
    end
    if (o.to) return;
    o.op  = apu_op;
    o.rs1 = apu_operands[0];
    o.rs2 = apu_operands[1];
    o.rs3 = apu_operands[2];
    o.flg = apu_flags_o;
    repeat (gd) tick();
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    repeat (rl - 1) tick();
    apu_rvalid  = 1'b1;
    apu_result  = res;
    apu_flags_i = f;
    tick();
    apu_rvalid  = 1'b0;
    o.wbv       = wb_valid;
    o.wberr     = wb_err;
    o.wbrd      = wb_rd;
    o.wbd       = wb_data;
    o.wbf       = wb_flags;
    o.req_after = apu_req;
  endtask

  task automatic test_reset();
    n_reset     = 1'b0;
    issue_valid = 1'b0;
    set_issue(mk(6'd0, 32'd0, 5'd0, 1'b0));
    flush       = 1'b0;
    apu_gnt     = 1'b0;
    apu_rvalid  = 1'b0;
    apu_result  = '0;
    apu_flags_i = '0;
    #12;
    checks++;
    if ({apu_req, wb_valid, wb_err, busy, proto_err, issue_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctrl: req/wbv/err/busy/perr/rdy=%b want 000001",
               {apu_req, wb_valid, wb_err, busy, proto_err, issue_ready});
    end
    checks++;
    if ({apu_op, apu_operands, apu_flags_o, wb_rd, wb_data, wb_flags} !== '0) begin
      failures++;
      $display("FAIL reset_payload: op=%h ops=%h flg=%h wbrd=%h wbd=%h wbf=%h want all 0",
               apu_op, apu_operands, apu_flags_o, wb_rd, wb_data, wb_flags);
    end
    @(negedge clk);
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ent_t e = mk(6'h01, 32'd17, 5'd5, 1'b1);
    set_issue(e);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({apu_req, busy} !== 2'b01) begin
      failures++;
      $display("FAIL single_after_push: req=%b busy=%b want 0 1", apu_req, busy);
    end
    tick();
    checks++;
    if ({apu_req, apu_op, apu_operands[0]} !== {1'b1, 6'h01, 32'd17}) begin
      failures++;
      $display("FAIL single_req: req=%b op=%h rs1=%0d want 1 01 17",
               apu_req, apu_op, apu_operands[0]);
    end
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    checks++;
    if (apu_req !== 1'b0) begin
      failures++;
      $display("FAIL single_req_len: req=%b after grant, want 0", apu_req);
    end
    tick();
    apu_rvalid  = 1'b1;
    apu_result  = 32'd16;
    apu_flags_i = 5'h0;
    tick();
    apu_rvalid = 1'b0;
    checks++;
    if ({wb_valid, wb_err, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd5, 32'd16}) begin
      failures++;
      $display("FAIL single_wb: wbv=%b err=%b rd=%0d data=%0d want 1 0 5 16",
               wb_valid, wb_err, wb_rd, wb_data);
    end
    tick();
    checks++;
    if ({wb_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle: wbv=%b busy=%b want 0 0", wb_valid, busy);
    end
  endtask

  task automatic test_gnt_stall();
    ent_t a = mk(6'h02, 32'hA0A0_0001, 5'd1, 1'b1);
    ent_t b = mk(6'h03, 32'hB0B0_0002, 5'd2, 1'b1);
    ent_t c = mk(6'h04, 32'hC0C0_0003, 5'd3, 1'b1);
    logic [117:0] exp_pl;
    int bad;
    obs_t o;
    exp_pl = {1'b1, a.op, a.rs3, a.rs2, a.rs1, a.flags};
    set_issue(a);
    issue_valid = 1'b1;
    tick();
    set_issue(b);
    tick();
    set_issue(c);
    bad = 0;
    for (int cy = 1; cy <= 5; cy++) begin
      if ({apu_req, apu_op, apu_operands, apu_flags_o} !== exp_pl) bad++;
      if (cy == 2) begin
        issue_valid = 1'b0;
        checks++;
        if (issue_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_full: issue_ready=%b want 0", issue_ready);
        end
      end
      if (cy == 5) apu_gnt = 1'b1;
      tick();
    end
    apu_gnt = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_stable: %0d of 5 cycles unstable, want 0", bad);
    end
    apu_rvalid = 1'b1;
    apu_result = 32'h1111;
    tick();
    apu_rvalid = 1'b0;
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 32'h1111}) begin
      failures++;
      $display("FAIL stall_wb_a: wbv=%b rd=%0d data=%h want 1 1 1111", wb_valid, wb_rd, wb_data);
    end
    serve(0, 1, 32'h2222, 5'h2, o);
    checks++;
    if (o.to || o.op !== b.op || o.rs1 !== b.rs1 || o.wbd !== 32'h2222) begin
      failures++;
      $display("FAIL stall_b: to=%b op=%h rs1=%h wbd=%h want 0 %h %h 2222",
               o.to, o.op, o.rs1, o.wbd, b.op, b.rs1);
    end
    serve(1, 2, 32'h3333, 5'h3, o);
    checks++;
    if (o.to || o.op !== c.op || o.rs1 !== c.rs1 || o.wbrd !== 5'd3) begin
      failures++;
      $display("FAIL stall_c: to=%b op=%h rs1=%h wbrd=%0d want 0 %h %h 3",
               o.to, o.op, o.rs1, o.wbrd, c.op, c.rs1);
    end
  endtask

  task automatic test_back_to_back();
    ent_t e[3];
    obs_t o[3];
    for (int i = 0; i < 3; i++) e[i] = mk(6'(6'h10 + i), $urandom, 5'(10 + i), 1'b1);
    fork
      begin
        bit ok;
        for (int i = 0; i < 3; i++) issue(e[i], ok);
      end
      begin
        for (int i = 0; i < 3; i++) serve(0, 1, 32'(100 + i), 5'(i), o[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o[i].to || o[i].op !== e[i].op || o[i].wbd !== 32'(100 + i) ||
          o[i].wbrd !== e[i].rd) begin
        failures++;
        $display("FAIL b2b_order[%0d]: to=%b op=%h wbd=%0d rd=%0d want 0 %h %0d %0d",
                 i, o[i].to, o[i].op, o[i].wbd, o[i].wbrd, e[i].op, 100 + i, e[i].rd);
      end
    end
    checks++;
    if ({o[0].req_after, o[1].req_after, o[2].req_after} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_next_req: req after rvalid=%b want 110",
               {o[0].req_after, o[1].req_after, o[2].req_after});
    end
  endtask

  task automatic test_nowb_flush();
    int reqs;
    set_issue(mk(6'h20, 32'd1, 5'd6, 1'b0));
    issue_valid = 1'b1;
    tick();
    set_issue(mk(6'h21, 32'd2, 5'd7, 1'b1));
    tick();
    set_issue(mk(6'h22, 32'd3, 5'd8, 1'b1));
    apu_gnt = 1'b1;
    tick();
    issue_valid = 1'b0;
    apu_gnt     = 1'b0;
    flush       = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_busy_wait: busy=%b want 1", busy);
    end
    tick();
    flush       = 1'b0;
    apu_rvalid  = 1'b1;
    apu_result  = 32'hDEAD;
    tick();
    apu_rvalid = 1'b0;
    checks++;
    if ({wb_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL flush_nowb: wbv=%b busy=%b want 0 0", wb_valid, busy);
    end
    reqs = 0;
    for (int k = 0; k < 10; k++) begin
      if (apu_req !== 1'b0) reqs++;
      tick();
    end
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL flush_dropped: apu_req seen %0d cycles want 0", reqs);
    end
  endtask

  task automatic test_timeout();
    int k;
    set_issue(mk(6'h30, 32'd5, 5'd9, 1'b1));
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    tick();
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (wb_valid === 1'b1) break;
    end
    checks++;
    if (k != 9) begin
      failures++;
      $display("FAIL timeout_latency: wb_valid after %0d cycles want 9", k);
    end
    checks++;
    if ({wb_err, wb_data, wb_rd} !== {1'b1, 32'd0, 5'd9}) begin
      failures++;
      $display("FAIL timeout_wb: err=%b data=%h rd=%0d want 1 0 9", wb_err, wb_data, wb_rd);
    end
    tick();
    apu_rvalid = 1'b1;
    apu_result = 32'h5555;
    tick();
    apu_rvalid = 1'b0;
    checks++;
    if ({proto_err, wb_valid} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_late_rvalid: perr=%b wbv=%b want 1 0", proto_err, wb_valid);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    set_issue(mk(6'h31, 32'd6, 5'd4, 1'b1));
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    tick();
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    tick();
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if ({apu_req, wb_valid, busy, proto_err, issue_ready, apu_op} !== {5'b00001, 6'd0}) begin
      failures++;
      $display("FAIL async_reset: req=%b wbv=%b busy=%b perr=%b rdy=%b op=%h want 0 0 0 0 1 0",
               apu_req, wb_valid, busy, proto_err, issue_ready, apu_op);
    end
    tick();
    tick();
    n_reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (wb_valid !== 1'b0 || apu_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL async_reset_after: %0d cycles with wb_valid/apu_req want 0", bad);
    end
  endtask

  task automatic test_random();
    localparam int N = 30;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < N; i++) begin
          ent_t e;
          bit ok;
          repeat ($urandom_range(0, 3)) tick();
          e = mk(6'($urandom), $urandom, 5'($urandom), 1'($urandom));
          issue(e, ok);
          if (ok) exp_q.push_back(e);
        end
      end
      begin
        for (int i = 0; i < N; i++) begin
          obs_t o;
          ent_t e;
          logic [31:0] res;
          logic [4:0]  f;
          res = $urandom;
          f   = 5'($urandom);
          serve($urandom_range(0, 3), $urandom_range(1, 6), res, f, o);
          checks++;
          if (o.to || exp_q.size() == 0) begin
            failures++;
            $display("FAIL rand_req[%0d]: no request or empty model (to=%b size=%0d)",
                     i, o.to, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            checks++;
            if ({o.op, o.rs1, o.rs2, o.rs3, o.flg} !== {e.op, e.rs1, e.rs2, e.rs3, e.flags}) begin
              failures++;
              $display("FAIL rand_payload[%0d]: op=%h rs1=%h flg=%h want %h %h %h",
                       i, o.op, o.rs1, o.flg, e.op, e.rs1, e.flags);
            end
            checks++;
            if (o.wbv !== e.wb) begin
              failures++;
              $display("FAIL rand_wbv[%0d]: wb_valid=%b want %b", i, o.wbv, e.wb);
            end
            if (e.wb) begin
              checks++;
              if ({o.wberr, o.wbrd, o.wbd, o.wbf} !== {1'b0, e.rd, res, f}) begin
                failures++;
                $display("FAIL rand_wb[%0d]: err=%b rd=%0d data=%h flg=%h want 0 %0d %h %h",
                         i, o.wberr, o.wbrd, o.wbd, o.wbf, e.rd, res, f);
              end
            end
          end
        end
      end
    join
    tick();
    checks++;
    if ({busy, proto_err} !== 2'b00) begin
      failures++;
      $display("FAIL rand_end: busy=%b perr=%b want 0 0", busy, proto_err);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_gnt_stall();
    test_back_to_back();
    test_nowb_flush();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apu_dispatcher.md
# apu_dispatcher

Core-side initiator of the APU offload protocol: accepts vector/CSR instructions from the scalar core's issue stage, buffers them in a two-entry queue, drives `apu_req`/`apu_op`/`apu_operands`/`apu_flags_o` toward `accelerator_top`, and waits for the matching `apu_gnt` and `apu_rvalid`. It returns `apu_result` and the 5-bit accelerator flags to the core's register-file write port. It also enforces one-outstanding-transaction ordering and a response timeout.

## Interface
- `DEPTH`, 2: request queue entries (power of two, ≥2).
- `TIMEOUT`, 255: max cycles in WAIT_RESP before an error completion; 0 disables.
- `clk` in 1: single clock, rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: core offers an instruction.
- `issue_ready` out 1: queue not full; a transfer occurs when valid&&ready.
- `issue_op` in 6: APU opcode.
- `issue_operands` in 3x32: rs1, rs2, rs3/immediate values.
- `issue_flags` in 15: APU flags (vsew/vlmul hints, func bits).
- `issue_rd` in 5: scalar destination register.
- `issue_wb` in 1: the instruction returns a scalar result.
- `flush` in 1: drop all queued, not-yet-requested entries.
- `apu_req` out 1: request to accelerator.
- `apu_op` out 6, `apu_operands` out 3x32, `apu_flags_o` out 15: request payload.
- `apu_gnt` in 1: accelerator accepts the request.
- `apu_rvalid` in 1: result valid.
- `apu_result` in 32, `apu_flags_i` in 5: response payload.
- `wb_valid` out 1: one-cycle writeback strobe.
- `wb_rd` out 5, `wb_data` out 32, `wb_flags` out 5: writeback payload.
- `wb_err` out 1: the completion is a timeout, with data forced to 0.
- `busy` out 1: queue non-empty or FSM not IDLE (core fence/stall).
- `proto_err` out 1: sticky; set by `apu_rvalid` outside WAIT_RESP or `apu_gnt` without `apu_req`.

## Operation
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE → REQ when the queue is non-empty. The head entry is popped into the request register on that transition.
- REQ:
  - `apu_req`=1 and the payload is held stable from the request register.
  - On `apu_gnt`=1 → WAIT_RESP and the timeout counter clears.
  - `flush` has no effect on a request already in REQ; it must complete.
- WAIT_RESP:
  - On `apu_rvalid`=1, capture the result. If the queue is non-empty go → REQ directly, popping the next head; otherwise → IDLE.
  - The counter increments each cycle. On reaching `TIMEOUT`, complete with `wb_err`=1 and leave by the same rule.
- Writeback:
  - `wb_valid` pulses one cycle after completion, only if the entry's `issue_wb`=1. No-writeback completions produce no strobe.
  - `wb_err` completions always pulse `wb_valid` so the core can trap.
- Queue behaviour:
  - Push and pop in the same cycle are allowed when full; `issue_ready` reflects the pre-pop count, i.e. no bypass.
  - `flush` empties the queue and takes priority over a simultaneous push; the pushed entry is dropped.
- Ordering: strictly in order, with at most one transaction between `apu_gnt` and `apu_rvalid`.
- A late `apu_rvalid` after a timeout is ignored for writeback and sets `proto_err`.
- Counter width is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.

## Timing
- Reset values: `apu_req`=0, all payload outputs 0, `wb_*`=0, `issue_ready`=1, `busy`=0, `proto_err`=0, FSM=IDLE, queue empty.
- Reset asserted mid-transaction abandons the transaction immediately, with no writeback.
- Issue to `apu_req`: 1 cycle minimum (push at edge N, IDLE→REQ at N+1, `apu_req` high during N+1).
- `apu_gnt` is sampled at the edge where `apu_req`=1. The earliest next `apu_req` for the following entry is the cycle after `apu_rvalid`.
- `apu_rvalid` is accepted from the cycle after the gnt edge onward.
- `wb_valid` is registered: rvalid at edge M gives `wb_valid` high during the cycle after M.
- Back-to-back throughput is one transaction per (gnt latency + response latency + 1) cycles.

## Structure
- Add to `accelerator_pkg`:
  - `apu_req_t` packed struct {op[5:0], operands[2:0][31:0], flags[14:0], rd[4:0], wb}.
  - `apu_disp_state_t` enum {DISP_IDLE, DISP_REQ, DISP_WAIT_RESP}.
- Sub-module `apu_req_fifo`: synchronous FIFO of `apu_req_t` with parameter `DEPTH`, push/pop/flush, full/empty, and asynchronous active-low reset on pointers and count.
- The top-level `apu_dispatcher` holds the FSM, request register, timeout counter, writeback register and `proto_err`.

## Test plan
- Single request:
  - Stimulus: issue op=6'h01, rs1=32'd17, wb=1, rd=5; gnt in the first REQ cycle; rvalid 2 cycles later with result=32'd16, flags=5'h0.
  - Required: `apu_req` high for exactly 1 cycle, then `wb_valid`, `wb_rd`=5, `wb_data`=16 one cycle after rvalid.
- Gnt stall: gnt withheld 4 cycles → `apu_req` and payload are stable for 5 cycles, and the queue keeps accepting until full (`issue_ready`=0 after 2 more pushes).
- Back-to-back: 3 issues in consecutive cycles, each rvalid 1 cycle after gnt → requests go out in order, the second `apu_req` rises the cycle after the first rvalid, and the third waits on `issue_ready`.
- No-writeback plus flush:
  - Stimulus: an entry with wb=0, followed by 2 queued entries; `flush` asserted during WAIT_RESP.
  - Required: no `wb_valid` for the wb=0 entry, the 2 queued entries never reach `apu_req`, and `busy` drops after the rvalid.
- Timeout: TIMEOUT=8 with rvalid never arriving → `wb_valid` and `wb_err`=1 with `wb_data`=0 nine cycles after gnt; a later rvalid sets `proto_err`=1 and produces no writeback.
- Async reset: assert `n_reset` low during WAIT_RESP → all outputs return to reset values within the same cycle, and no writeback occurs after release.
